button_conditioner: RTL and testbench

Input conditioning stage for the digital lock: takes the four raw push-button lines, synchronises and debounces each one, and emits single-cycle key events (code plus valid strobe) to the lock state machine, which only ever sees clean, one-per-press key strokes. It also exports the debounced button levels, which the LED/display logic uses directly.

---
 rtl/button_conditioner.sv | 87 ++++++++
 tb/tb_button_conditioner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces four buttons and emits one key event per press.
// Auto-repeat of the held key is built only when BTN_REPEAT_EN is defined.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1024,
  parameter int REPEAT_PERIOD   = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] button,
  output logic       key_valid,
  output logic [1:0] key_code,
  output logic       key_repeat,
  output logic [3:0] btn_level,
  output logic       collision
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [3:0] meta, sync, flip, press;
  logic [CW-1:0] cnt [4];
  logic [1:0] low, tracked;
  logic multi, rep_fire;
  always_comb begin
    for (int i = 0; i < 4; i++) flip[i] = sync[i] != btn_level[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1);
    press = flip & ~btn_level;
    low = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
    multi = (press & (press - 4'd1)) != 4'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta <= '0;
      sync <= '0;
      btn_level <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      meta <= button;
      sync <= meta;
      btn_level <= btn_level ^ flip;
      for (int i = 0; i < 4; i++) cnt[i] <= (sync[i] == btn_level[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      key_valid <= 1'b0;
      key_code <= 2'd0;
      collision <= 1'b0;
    end else begin
      key_valid <= |press | rep_fire;
      key_code <= |press ? low : rep_fire ? tracked : key_code;
      collision <= multi;
    end
`ifdef BTN_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rcnt;
  logic active, first;
  // first repeat waits REPEAT_DELAY after the initial event, later ones REPEAT_PERIOD
  assign rep_fire = active && btn_level[tracked] &&
                    rcnt == (first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tracked <= 2'd0;
      rcnt <= '0;
      active <= 1'b0;
      first <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      key_repeat <= ~|press & rep_fire;
      if (|press) begin
        tracked <= low;
        active <= 1'b1;
        first <= 1'b1;
        rcnt <= '0;
      end else if (active && !btn_level[tracked]) begin
        active <= 1'b0;
        rcnt <= '0;
      end else if (rep_fire) begin
        first <= 1'b0;
        rcnt <= '0;
      end else if (active) rcnt <= rcnt + 1'b1;
    end
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign tracked = 2'd0;
  assign rep_fire = 1'b0;
  assign key_repeat = 1'b0;
`endif
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus with an event scoreboard checked by a negedge monitor.
module tb_button_conditioner;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] button = 4'h0;
  logic key_valid, key_repeat, collision;
  logic [1:0] key_code;
  logic [3:0] btn_level;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {int cyc; logic [1:0] code; logic rep; logic col;} ev_t;
  ev_t q[$];
  ev_t e;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
    .clk(clk), .rst(rst), .button(button), .key_valid(key_valid), .key_code(key_code),
    .key_repeat(key_repeat), .btn_level(btn_level), .collision(collision));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int d, input logic [1:0] code, input logic rep, input logic col);
    q.push_back('{cyc + d, code, rep, col});
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_event: got key_valid=0 expected code=%0d repeat=%0b at cycle %0d", q[0].code, q[0].rep, q[0].cyc);
      void'(q.pop_front());
    end
    if (key_valid) begin
      checks++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        failures++;
        $display("FAIL unexpected_event: got code=%0d repeat=%0b collision=%0b at cycle %0d, expected none", key_code, key_repeat, collision, cyc);
      end else begin
        e = q.pop_front();
        if ({key_code, key_repeat, collision} !== {e.code, e.rep, e.col}) begin
          failures++;
          $display("FAIL event: got code=%0d repeat=%0b collision=%0b expected code=%0d repeat=%0b collision=%0b at cycle %0d",
                   key_code, key_repeat, collision, e.code, e.rep, e.col, cyc);
        end
      end
    end else if (collision || key_repeat) begin
      checks++;
      failures++;
      $display("FAIL stray_strobe: got collision=%0b repeat=%0b expected 0 without key_valid at cycle %0d", collision, key_repeat, cyc);
    end
  end

  initial begin
    tick(2);
    chk("reset_outputs", {key_valid, key_code, key_repeat, btn_level}, 8'h00);
    chk("reset_collision", collision, 0);
    rst = 1'b0;
    tick(3);
    // clean press and release of button 2
    button[2] = 1'b1;
    expect_ev(6, 2, 0, 0);
    tick(5);
    chk("press_level_early", btn_level, 8'h0);
    tick(1);
    chk("press_level", btn_level, 8'h4);
    tick(4);
    button[2] = 1'b0;
    tick(5);
    chk("release_level_early", btn_level, 8'h4);
    tick(1);
    chk("release_level", btn_level, 8'h0);
    tick(4);
    // glitch: 3-cycle pulse, then single-cycle bounce
    foreach (button[i]) ;
    for (int i = 0; i < 8; i++) begin
      button[1] = (i < 3) || (i == 4) || (i == 6);
      tick(1);
      chk("glitch_level", btn_level, 8'h0);
    end
    button[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_settle_level", btn_level, 8'h0);
    end
    // simultaneous press of buttons 3 and 0
    button = 4'b1001;
    expect_ev(6, 0, 0, 1);
    tick(6);
    chk("collision_level", btn_level, 8'h9);
    tick(4);
    button = 4'h0;
    tick(6);
    chk("collision_release", btn_level, 8'h0);
    tick(4);
    // press while another button is held
    button[3] = 1'b1;
    expect_ev(6, 3, 0, 0);
    tick(10);
    button[1] = 1'b1;
    expect_ev(6, 1, 0, 0);
    tick(6);
    chk("held_level", btn_level, 8'ha);
    button = 4'h0;
    tick(10);
    chk("held_release", btn_level, 8'h0);
    // reset with button 0 counter at 2
    button[0] = 1'b1;
    tick(4);
    rst = 1'b1;
    #1 chk("reset_mid_outputs", {key_valid, key_code, key_repeat, btn_level}, 8'h00);
    tick(1);
    rst = 1'b0;
    expect_ev(6, 0, 0, 0);
    tick(6);
    chk("after_reset_level", btn_level, 8'h1);
    tick(2);
    // asynchronous reset mid-cycle while level is high
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {key_valid, key_code, key_repeat, btn_level}, 8'h00);
    tick(1);
    rst = 1'b0;
    expect_ev(6, 0, 0, 0);
    tick(6);
    chk("async_reset_relevel", btn_level, 8'h1);
    tick(2);
    button = 4'h0;
    tick(10);
`ifdef BTN_REPEAT_EN
    // auto-repeat of button 1
    button[1] = 1'b1;
    expect_ev(6, 1, 0, 0);
    expect_ev(26, 1, 1, 0);
    expect_ev(34, 1, 1, 0);
    expect_ev(42, 1, 1, 0);
    tick(43);
    button[1] = 1'b0;
    tick(20);
    // preemption by button 2
    button[1] = 1'b1;
    expect_ev(6, 1, 0, 0);
    expect_ev(26, 1, 1, 0);
    tick(27);
    button[2] = 1'b1;
    expect_ev(6, 2, 0, 0);
    expect_ev(26, 2, 1, 0);
    expect_ev(34, 2, 1, 0);
    tick(35);
    button = 4'h0;
    tick(15);
`endif
    tick(5);
    chk("queue_drained", 8'(q.size()), 8'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion before 100000");
    $fatal(1);
  end
endmodule
